signed_result_display: RTL
==========================

// Module: signed_result_display
// PURPOSE
// - Consumer end of the calculator's sign-magnitude result interface (unsigned magnitude + negative flag).
// - Converts the magnitude to BCD with a sequential shift-add-3 (double dabble) engine.
// - Drives the Basys-3 4-digit seven-segment display: a minus sign on the leftmost digit, then hundreds/tens/units.
// - Sits between the arithmetic units and the board display pins.
// PARAMETERS
// - WIDTH        8       magnitude width; BCD result is 3 digits (max 255)
// - REFRESH_DIV  100000  clk cycles per digit slot (100 MHz -> 1 kHz per digit, 250 Hz frame)
// PORTS
// - clk     in   1      system clock; all logic on its rising edge
// - rst     in   1      synchronous, active-high reset
// - mag_in  in   WIDTH  unsigned magnitude from the arithmetic unit
// - neg_in  in   1      1 = result negative
// - load    in   1      1-cycle strobe; capture mag_in/neg_in
// - busy    out  1      high while a conversion is in progress
// - done    out  1      1-cycle pulse when a new value reaches the display
// - an      out  4      digit enables, active-low, one-hot; an[3] is the leftmost digit
// - seg     out  7      segments {g,f,e,d,c,b,a}, active-low
// - dp      out  1      decimal point, active-low; held 1 (off)
// BEHAVIOUR
// - Reset: busy=0, done=0, an=4'b1110, seg shows '0' on the units digit, dp=1.
//   Display registers become {sign=0, digits=000}; the refresh counter and digit index become 0.
// - FSM: IDLE -> CONV -> DONE -> IDLE.
//   - IDLE: load=1 captures the magnitude into the shift register, clears the BCD accumulator, latches neg_in, and moves to CONV.
//   - CONV: runs exactly WIDTH cycles. Each cycle, first add 3 to every BCD nibble >= 5, then shift {bcd, shift_reg} left by 1. busy=1.
//   - DONE: one cycle with done=1, busy=0. The display registers load the BCD digits and the sign on this same edge.
// - Latency: load accepted at edge N; done is high in cycle N+WIDTH+1; the new value is visible from that cycle.
// - load is ignored outside IDLE; the display keeps the previous value until DONE.
// - load and rst together: rst wins.
// - Reset during CONV: conversion is aborted and nothing reaches the display.
// - Negative zero: mag_in=0 with neg_in=1 is displayed as "0" with no minus sign. The latched sign is ANDed with (mag != 0).
// - Magnitude is unsigned. 8'h80 displays "-128" when neg_in=1.
// - Refresh counter: counts 0..REFRESH_DIV-1. On wrap, the digit index increments mod 4 (wraps 3 -> 0).
//   an = ~(4'b0001 << idx). seg and an change on the same edge, so there is no cross-digit ghosting cycle.
// - Digit 3: minus (only segment g lit, seg=7'b0111111) if the sign is set, otherwise blank (7'h7F).
// - Digits 2..0: hundreds, tens, units, through the BCD-to-segment decoder.
// CONFIGURATION
// - LEADING_ZERO_BLANK_EN defined:
//   - Hundreds digit is blank when it is 0.
//   - Tens digit is blank when both hundreds and tens are 0.
//   - Units digit is always shown.
//   - With the sign set, the minus stays on digit 3 (it does not float right).
// - Not defined: all three numeric digits are always shown, zero-padded ("007", "-007").
// STRUCTURE
// - Package calc_pkg:
//   - Seven-segment constants: SEG_BLANK=7'h7F, SEG_MINUS=7'h3F, patterns for digits 0-9.
//   - FSM state typedef {IDLE, CONV, DONE}.
//   - BCD digit typedef (logic [3:0]).
// - Sub-module sevenseg_decoder: combinational 4-bit BCD -> 7-bit active-low segments.
//   - Codes >9 map to SEG_BLANK.
//   - Instantiated once, after the digit mux.
// - Everything else (FSM, shift-add-3 datapath, refresh counter, digit mux) lives in signed_result_display.
// TESTING (REFRESH_DIV overridden to 4 for simulation)
// - Reset then idle: an=1110, seg=7'b1000000 ('0'), busy=0, done=0.
// - load with mag_in=8'd200, neg_in=0: busy high for 8 cycles, done pulses 9 cycles after load.
//   Scanned digits read blank, 2, 0, 0.
// - load with mag_in=8'h80, neg_in=1: the scan reads minus, 1, 2, 8.
// - load with mag_in=0, neg_in=1: no minus on digit 3; the units digit shows '0'.
// - load mid-conversion with a different value: ignored, and the first value is displayed.
//   rst at CONV cycle 4: the display keeps the reset value and busy=0 on the next cycle.
// - mag_in=8'd7: with LEADING_ZERO_BLANK_EN the digits read blank, blank, blank, 7; without it they read blank, 0, 0, 7.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : calc_pkg                                                          |
// | Brief  : Shared types and constants for the calculator result display:    |
// |          seven-segment patterns (active-low {g,f,e,d,c,b,a}), the         |
// |          conversion FSM state type, the BCD digit type and the add-3      |
// |          correction used by the double-dabble engine.                     |
// | Rev    : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package calc_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   // Number of BCD digits produced by the converter (0..999 range)
   localparam int BCD_DIGITS = 3;

   typedef logic [3:0] bcd_digit_t;

   // Any code above 9 decodes to a dark digit; used to blank a slot
   localparam bcd_digit_t BCD_BLANK = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   // Double-dabble correction: a nibble of 5 or more would exceed 9 after
   // the next shift, so pre-add 3 to make it carry into the next digit.
   function automatic bcd_digit_t bcd_adjust(input bcd_digit_t d);
      return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sevenseg_decoder                                                  |
// | Brief  : Combinational BCD digit to active-low seven-segment decoder.     |
// |          Codes above 9 produce an all-dark digit.                         |
// | Ports  : bcd [3:0] in  - BCD digit code                                   |
// |          seg [6:0] out - segments {g,f,e,d,c,b,a}, active-low             |
// | Rev    : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sevenseg_decoder
   import calc_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/signed_result_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : signed_result_display                                             |
// | Brief  : Takes a sign-magnitude result, converts the magnitude to BCD     |
// |          with a sequential shift-add-3 engine and scans it onto a 4-digit |
// |          seven-segment display: sign on the leftmost digit, then          |
// |          hundreds/tens/units.                                             |
// | Ports  : clk, rst (sync, active-high)                                     |
// |          mag_in [WIDTH-1:0] / neg_in / load  - result capture interface    |
// |          busy / done                          - conversion status          |
// |          an [3:0] / seg [6:0] / dp            - display pins, active-low   |
// | Config : LEADING_ZERO_BLANK_EN - when defined, leading zeros of the       |
// |          hundreds and tens digits are blanked; units always shown.        |
// | Rev    : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module signed_result_display
   import calc_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int REFRESH_DIV = 100000
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] mag_in,
   input  logic             neg_in,
   input  logic             load,
   output logic             busy,
   output logic             done,
   output logic [3:0]       an,
   output logic [6:0]       seg,
   output logic             dp
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BCD_W = 4 * BCD_DIGITS;

   state_t             state_q,     state_d;
   logic [WIDTH-1:0]   shift_q,     shift_d;
   logic [BCD_W-1:0]   bcd_q,       bcd_d;
   logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
   logic               sign_q,      sign_d;
   logic [BCD_W-1:0]   disp_bcd_q,  disp_bcd_d;
   logic               disp_sign_q, disp_sign_d;
   logic [REF_W-1:0]   refresh_q,   refresh_d;
   logic [1:0]         idx_q,       idx_d;

   logic [BCD_W-1:0]   bcd_adj;
   bcd_digit_t         dig_hund, dig_tens, dig_units;
   bcd_digit_t         dig_code;
   logic [6:0]         dec_seg;

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bcd_q       <= '0;
         bit_cnt_q   <= '0;
         sign_q      <= 1'b0;
         disp_bcd_q  <= '0;
         disp_sign_q <= 1'b0;
         refresh_q   <= '0;
         idx_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bcd_q       <= bcd_d;
         bit_cnt_q   <= bit_cnt_d;
         sign_q      <= sign_d;
         disp_bcd_q  <= disp_bcd_d;
         disp_sign_q <= disp_sign_d;
         refresh_q   <= refresh_d;
         idx_q       <= idx_d;
      end
   end

   // ---------------------------------------------------------------------
   // Add-3 correction on every BCD nibble ahead of the shift
   // ---------------------------------------------------------------------
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         bcd_adj[4*i +: 4] = bcd_adjust(bcd_q[4*i +: 4]);
      end
   end

   // ---------------------------------------------------------------------
   // Conversion FSM and datapath
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bcd_d       = bcd_q;
      bit_cnt_d   = bit_cnt_q;
      sign_d      = sign_q;
      disp_bcd_d  = disp_bcd_q;
      disp_sign_d = disp_sign_q;
      busy        = 1'b0;
      done        = 1'b0;

      case (state_q)
         IDLE: begin
            if (load) begin
               shift_d   = mag_in;
               bcd_d     = '0;
               bit_cnt_d = '0;
               // A zero magnitude never shows a minus sign
               sign_d    = neg_in & (mag_in != '0);
               state_d   = CONV;
            end
         end

         CONV: begin
            busy      = 1'b1;
            bcd_d     = {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
               // Final shift: the display takes the finished result on the
               // same edge that enters DONE, so it is visible alongside done.
               state_d     = DONE;
               disp_bcd_d  = bcd_d;
               disp_sign_d = sign_q;
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Refresh counter and digit index
   // ---------------------------------------------------------------------
   always_comb begin
      refresh_d = refresh_q + REF_W'(1);
      idx_d     = idx_q;
      if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         idx_d     = idx_q + 2'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Digit mux; a blank slot is expressed as an out-of-range code so the
   // single decoder handles it.
   // ---------------------------------------------------------------------
   assign dig_hund  = disp_bcd_q[11:8];
   assign dig_tens  = disp_bcd_q[7:4];
   assign dig_units = disp_bcd_q[3:0];

   always_comb begin
      dig_code = BCD_BLANK;
      case (idx_q)
         2'd0: dig_code = dig_units;
         2'd1: begin
            dig_code = dig_tens;
`ifdef LEADING_ZERO_BLANK_EN
            if (dig_hund == 4'd0 && dig_tens == 4'd0) begin
               dig_code = BCD_BLANK;
            end
`endif
         end
         2'd2: begin
            dig_code = dig_hund;
`ifdef LEADING_ZERO_BLANK_EN
            if (dig_hund == 4'd0) begin
               dig_code = BCD_BLANK;
            end
`endif
         end
         default: dig_code = BCD_BLANK;
      endcase
   end

   sevenseg_decoder u_decoder (
      .bcd (dig_code),
      .seg (dec_seg)
   );

   // an and seg both derive from idx_q, so they switch on the same edge
   assign seg = (idx_q == 2'd3) ? (disp_sign_q ? SEG_MINUS : SEG_BLANK) : dec_seg;
   assign an  = ~(4'b0001 << idx_q);
   assign dp  = 1'b1;

endmodule
`default_nettype wire
